reg_file: RTL and testbench

//  Integer register file, x0..x31, for the RISC-V pipeline. Receives the write stage's data/address/v_out stream.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/reg_file_if.sv | 36 +++
 rtl/reg_file_scoreboard.sv | 61 ++++++
 rtl/reg_file.sv | 92 +++++++++
 tb/tb_reg_file.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, register-file typedefs, opcodes.
// Imported by the register file, its scoreboard and the interface.
// Optional feature in this slice: REGFILE_BYPASS_EN (see reg_file.sv).
package riscv_pkg;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int ADDR_W = 5;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]   word_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // Stores and branches carry no destination; their write-back uses address 0.
   function automatic logic op_writes_rd(input logic [6:0] op);
      return (op != OP_STORE) && (op != OP_BRANCH);
   endfunction

endpackage

// File: rtl/reg_file_if.sv
// Bundle of write-back, issue-request and read-result signals around reg_file.
// master = pipeline side (write stage + decode), slave = register file.
// Latency/backpressure are defined by reg_file; this is wiring only.
interface reg_file_if;
   import riscv_pkg::*;

   logic      wb_v;
   reg_addr_t wb_addr;
   word_t     wb_data;
   logic      v_in;
   logic      stall;
   reg_addr_t rs1_addr;
   reg_addr_t rs2_addr;
   logic      use_rs1;
   logic      use_rs2;
   reg_addr_t rd_addr;
   logic      wr_rd;
   word_t     rs1_data;
   word_t     rs2_data;
   logic      v_out;
   logic      r_out;
   logic      hazard;

   modport master (
      output wb_v, wb_addr, wb_data, v_in, stall, rs1_addr, rs2_addr,
             use_rs1, use_rs2, rd_addr, wr_rd,
      input  rs1_data, rs2_data, v_out, r_out, hazard
   );

   modport slave (
      input  wb_v, wb_addr, wb_data, v_in, stall, rs1_addr, rs2_addr,
             use_rs1, use_rs2, rd_addr, wr_rd,
      output rs1_data, rs2_data, v_out, r_out, hazard
   );

endinterface

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard: set on issue of a writer, cleared by write-back; raises hazard.
// Latency: hazard is combinational from the request; busy updates take effect the next cycle.
// Backpressure: hazard blocks the issue; set beats clear on the same index. Honours REGFILE_BYPASS_EN.
module reg_scoreboard
   import riscv_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      wb_v,
   input  reg_addr_t wb_addr,
   input  logic      v_in,
   input  logic      use_rs1,
   input  reg_addr_t rs1_addr,
   input  logic      use_rs2,
   input  reg_addr_t rs2_addr,
   input  logic      wr_rd,
   input  reg_addr_t rd_addr,
   input  logic      set_en,
   output logic      hazard
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [NREGS-1:0] blocked;

   // Effective busy view seen by the hazard check; x0 is never blocked.
   always_comb begin
      blocked    = busy_q;
`ifdef REGFILE_BYPASS_EN
      if (wb_v) begin
         blocked[wb_addr] = 1'b0;
      end
`endif
      blocked[0] = 1'b0;
   end

   assign hazard = v_in & ((use_rs1 & blocked[rs1_addr]) |
                           (use_rs2 & blocked[rs2_addr]) |
                           (wr_rd   & blocked[rd_addr]));

   // Next busy vector: clear on write-back first, so a same-index issue set wins.
   always_comb begin
      busy_d = busy_q;
      if (wb_v && wb_addr != '0) begin
         busy_d[wb_addr] = 1'b0;
      end
      if (set_en && rd_addr != '0) begin
         busy_d[rd_addr] = 1'b1;
      end
   end

   // Busy state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/reg_file.sv
// Integer register file x0..x31 with two registered read ports and a busy scoreboard.
// Latency: read data and v_out one cycle after an accepted issue; writes land at the clock edge.
// Backpressure: issue blocked by hazard, stall, or r_out=0 (low the cycle after a stall). Optional REGFILE_BYPASS_EN.
module reg_file
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   reg_file_if.slave  rf
);

   word_t regs_q [NREGS];
   word_t rs1_data_q, rs1_data_d;
   word_t rs2_data_q, rs2_data_d;
   logic  v_out_q;
   logic  r_out_q;
   logic  hazard;
   logic  accept;

   reg_scoreboard u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_v     (rf.wb_v),
      .wb_addr  (rf.wb_addr),
      .v_in     (rf.v_in),
      .use_rs1  (rf.use_rs1),
      .rs1_addr (rf.rs1_addr),
      .use_rs2  (rf.use_rs2),
      .rs2_addr (rf.rs2_addr),
      .wr_rd    (rf.wr_rd),
      .rd_addr  (rf.rd_addr),
      .set_en   (accept & rf.wr_rd),
      .hazard   (hazard)
   );

   assign accept = rf.v_in & r_out_q & ~hazard & ~rf.stall;

   // Read-port muxes; x0 is forced to zero, optional forwarding of a landing write-back.
   always_comb begin
      rs1_data_d = regs_q[rf.rs1_addr];
      rs2_data_d = regs_q[rf.rs2_addr];
`ifdef REGFILE_BYPASS_EN
      if (rf.wb_v && rf.wb_addr == rf.rs1_addr) begin
         rs1_data_d = rf.wb_data;
      end
      if (rf.wb_v && rf.wb_addr == rf.rs2_addr) begin
         rs2_data_d = rf.wb_data;
      end
`endif
      if (rf.rs1_addr == '0) begin
         rs1_data_d = '0;
      end
      if (rf.rs2_addr == '0) begin
         rs2_data_d = '0;
      end
   end

   // Storage array: write-back to x0 is dropped so x0 stays zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (rf.wb_v && rf.wb_addr != '0) begin
         regs_q[rf.wb_addr] <= rf.wb_data;
      end
   end

   // Read registers and handshake flags; data holds when no issue is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         v_out_q    <= 1'b0;
         r_out_q    <= 1'b1;
      end else begin
         v_out_q <= accept;
         r_out_q <= ~rf.stall;
         if (accept) begin
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
         end
      end
   end

   assign rf.rs1_data = rs1_data_q;
   assign rf.rs2_data = rs2_data_q;
   assign rf.v_out    = v_out_q;
   assign rf.r_out    = r_out_q;
   assign rf.hazard   = hazard;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a randomized run
// against an array-based reference model of the register file and scoreboard.
module tb_reg_file;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   reg_file_if rf_if ();

   reg_file dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (rf_if)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   word_t m_regs [32];
   bit    m_busy [32];
   bit    m_vout;
   bit    m_rout;
   word_t m_rs1;
   word_t m_rs2;
   bit    exp_hz;
   logic  act_hz;

   function automatic bit m_blocked(input int n);
      if (n == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (rf_if.wb_v && int'(rf_if.wb_addr) == n) return 1'b0;
`endif
      return m_busy[n];
   endfunction

   function automatic word_t m_read(input int n);
      if (n == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (rf_if.wb_v && int'(rf_if.wb_addr) == n) return rf_if.wb_data;
`endif
      return m_regs[n];
   endfunction

   task automatic set_wb(input bit v, input int a, input word_t d);
      rf_if.wb_v    = v;
      rf_if.wb_addr = reg_addr_t'(a);
      rf_if.wb_data = d;
   endtask

   task automatic set_issue(input bit v, input int r1, input int r2, input bit u1,
                            input bit u2, input int rd, input bit wr);
      rf_if.v_in     = v;
      rf_if.rs1_addr = reg_addr_t'(r1);
      rf_if.rs2_addr = reg_addr_t'(r2);
      rf_if.use_rs1  = u1;
      rf_if.use_rs2  = u2;
      rf_if.rd_addr  = reg_addr_t'(rd);
      rf_if.wr_rd    = wr;
   endtask

   task automatic idle();
      set_wb(0, 0, '0);
      set_issue(0, 0, 0, 0, 0, 0, 0);
      rf_if.stall = 1'b0;
   endtask

   // One clock: sample hazard before the edge, advance the model with the edge.
   task automatic step();
      bit acc;
      word_t r1, r2;
      #2;
      act_hz = rf_if.hazard;
      exp_hz = rf_if.v_in && ((rf_if.use_rs1 && m_blocked(int'(rf_if.rs1_addr))) ||
                              (rf_if.use_rs2 && m_blocked(int'(rf_if.rs2_addr))) ||
                              (rf_if.wr_rd   && m_blocked(int'(rf_if.rd_addr))));
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
         end
         m_rs1 = '0; m_rs2 = '0; m_vout = 1'b0; m_rout = 1'b1;
      end else begin
         acc = rf_if.v_in && m_rout && !exp_hz && !rf_if.stall;
         r1  = m_read(int'(rf_if.rs1_addr));
         r2  = m_read(int'(rf_if.rs2_addr));
         if (acc) begin
            m_rs1 = r1;
            m_rs2 = r2;
         end
         m_vout = acc;
         m_rout = !rf_if.stall;
         if (rf_if.wb_v && rf_if.wb_addr != 0) begin
            m_busy[rf_if.wb_addr] = 1'b0;
            m_regs[rf_if.wb_addr] = rf_if.wb_data;
         end
         if (acc && rf_if.wr_rd && rf_if.rd_addr != 0) m_busy[rf_if.rd_addr] = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      step();
      step();
      rst_n = 1'b1;
      total++; if (rf_if.v_out !== 1'b0) begin bad++; $display("FAIL reset_v_out got=%0b want=0", rf_if.v_out); end
      total++; if (rf_if.r_out !== 1'b1) begin bad++; $display("FAIL reset_r_out got=%0b want=1", rf_if.r_out); end
      total++; if (rf_if.rs1_data !== 32'h0) begin bad++; $display("FAIL reset_rs1 got=%h want=0", rf_if.rs1_data); end
      total++; if (rf_if.rs2_data !== 32'h0) begin bad++; $display("FAIL reset_rs2 got=%h want=0", rf_if.rs2_data); end
      total++; if (act_hz !== 1'b0) begin bad++; $display("FAIL reset_hazard got=%0b want=0", act_hz); end
   endtask

   task automatic test_basic_read();
      set_issue(1, 5, 0, 1, 1, 0, 0);
      step();
      total++; if (act_hz !== 1'b0) begin bad++; $display("FAIL basic_hazard got=%0b want=0", act_hz); end
      total++; if (rf_if.v_out !== 1'b1) begin bad++; $display("FAIL basic_v_out got=%0b want=1", rf_if.v_out); end
      total++; if (rf_if.rs1_data !== m_rs1) begin bad++; $display("FAIL basic_rs1 got=%h want=%h", rf_if.rs1_data, m_rs1); end
      total++; if (rf_if.rs2_data !== m_rs2) begin bad++; $display("FAIL basic_rs2 got=%h want=%h", rf_if.rs2_data, m_rs2); end
      idle();
      step();
      total++; if (rf_if.v_out !== 1'b0) begin bad++; $display("FAIL basic_v_out_drop got=%0b want=0", rf_if.v_out); end
   endtask

   task automatic test_write_read();
      set_wb(1, 7, 32'hDEADBEEF);
      step();
      idle();
      set_issue(1, 7, 0, 1, 0, 0, 0);
      step();
      total++; if (rf_if.rs1_data !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_x7 got=%h want=deadbeef", rf_if.rs1_data); end
      total++; if (rf_if.v_out !== m_vout) begin bad++; $display("FAIL wr_rd_v_out got=%0b want=%0b", rf_if.v_out, m_vout); end
      idle();
      set_wb(1, 0, 32'h1);
      step();
      idle();
      set_issue(1, 0, 7, 1, 1, 0, 0);
      step();
      total++; if (rf_if.rs1_data !== 32'h0) begin bad++; $display("FAIL wr_x0_read got=%h want=0", rf_if.rs1_data); end
      total++; if (rf_if.rs2_data !== m_rs2) begin bad++; $display("FAIL wr_x7_rs2 got=%h want=%h", rf_if.rs2_data, m_rs2); end
      idle();
   endtask

   task automatic test_raw();
      set_issue(1, 0, 0, 0, 0, 3, 1);
      step();
      set_issue(1, 3, 0, 1, 0, 0, 0);
      step();
      total++; if (act_hz !== 1'b1) begin bad++; $display("FAIL raw_hazard got=%0b want=1", act_hz); end
      total++; if (rf_if.v_out !== 1'b0) begin bad++; $display("FAIL raw_v_out got=%0b want=0", rf_if.v_out); end
      set_wb(1, 3, 32'h55);
      step();
      total++; if (act_hz !== exp_hz) begin bad++; $display("FAIL raw_wb_hazard got=%0b want=%0b", act_hz, exp_hz); end
      total++; if (rf_if.v_out !== m_vout) begin bad++; $display("FAIL raw_wb_v_out got=%0b want=%0b", rf_if.v_out, m_vout); end
      total++; if (rf_if.rs1_data !== m_rs1) begin bad++; $display("FAIL raw_wb_rs1 got=%h want=%h", rf_if.rs1_data, m_rs1); end
      set_wb(0, 0, '0);
      step();
      total++; if (rf_if.v_out !== 1'b1) begin bad++; $display("FAIL raw_late_v_out got=%0b want=1", rf_if.v_out); end
      total++; if (rf_if.rs1_data !== 32'h55) begin bad++; $display("FAIL raw_late_rs1 got=%h want=55", rf_if.rs1_data); end
      idle();
      step();
   endtask

   task automatic test_waw();
      set_issue(1, 0, 0, 0, 0, 4, 1);
      step();
      step();
      total++; if (act_hz !== 1'b1) begin bad++; $display("FAIL waw_hazard got=%0b want=1", act_hz); end
      set_wb(1, 4, 32'h44);
      step();
      total++; if (act_hz !== exp_hz) begin bad++; $display("FAIL waw_wb_hazard got=%0b want=%0b", act_hz, exp_hz); end
      set_wb(0, 0, '0);
      step();
      total++; if (act_hz !== exp_hz) begin bad++; $display("FAIL waw_after_hazard got=%0b want=%0b", act_hz, exp_hz); end
      idle();
      set_wb(1, 4, 32'h45);
      step();
      // x4 now free: write-back and a new writer of x4 in the same cycle
      set_wb(1, 4, 32'h46);
      set_issue(1, 0, 0, 0, 0, 4, 1);
      step();
      total++; if (rf_if.v_out !== 1'b1) begin bad++; $display("FAIL setclr_accept got=%0b want=1", rf_if.v_out); end
      set_wb(0, 0, '0);
      step();
      total++; if (act_hz !== 1'b1) begin bad++; $display("FAIL setclr_busy_kept got=%0b want=1", act_hz); end
      idle();
      set_wb(1, 4, 32'h47);
      step();
      idle();
   endtask

   task automatic test_stall();
      set_issue(1, 7, 3, 1, 1, 0, 0);
      step();
      rf_if.stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         total++; if (rf_if.v_out !== 1'b0) begin bad++; $display("FAIL stall_v_out[%0d] got=%0b want=0", i, rf_if.v_out); end
         total++; if (rf_if.r_out !== 1'b0) begin bad++; $display("FAIL stall_r_out[%0d] got=%0b want=0", i, rf_if.r_out); end
         total++; if (rf_if.rs1_data !== 32'hDEADBEEF) begin bad++; $display("FAIL stall_hold[%0d] got=%h want=deadbeef", i, rf_if.rs1_data); end
      end
      rf_if.stall = 1'b0;
      step();
      total++; if (rf_if.r_out !== 1'b1) begin bad++; $display("FAIL unstall_r_out got=%0b want=1", rf_if.r_out); end
      total++; if (rf_if.v_out !== 1'b0) begin bad++; $display("FAIL unstall_v_out got=%0b want=0", rf_if.v_out); end
      step();
      total++; if (rf_if.v_out !== 1'b1) begin bad++; $display("FAIL unstall_accept got=%0b want=1", rf_if.v_out); end
      total++; if (rf_if.rs2_data !== m_rs2) begin bad++; $display("FAIL unstall_rs2 got=%h want=%h", rf_if.rs2_data, m_rs2); end
      idle();
   endtask

   task automatic test_reset_mid();
      set_wb(1, 9, 32'hA5);
      step();
      idle();
      set_issue(1, 0, 0, 0, 0, 9, 1);
      step();
      idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      total++; if (rf_if.v_out !== 1'b0) begin bad++; $display("FAIL rstmid_v_out got=%0b want=0", rf_if.v_out); end
      total++; if (rf_if.r_out !== 1'b1) begin bad++; $display("FAIL rstmid_r_out got=%0b want=1", rf_if.r_out); end
      set_issue(1, 9, 0, 1, 0, 9, 1);
      step();
      total++; if (act_hz !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b want=0", act_hz); end
      total++; if (rf_if.rs1_data !== 32'h0) begin bad++; $display("FAIL rstmid_x9 got=%h want=0", rf_if.rs1_data); end
      idle();
      set_wb(1, 9, 32'h9);
      step();
      idle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         set_wb($urandom_range(0, 1), $urandom_range(0, 7), $urandom);
         set_issue($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 1));
         rf_if.stall = ($urandom_range(0, 7) == 0);
         step();
         total++; if (act_hz !== exp_hz) begin bad++; $display("FAIL rnd_hazard c=%0d got=%0b want=%0b", c, act_hz, exp_hz); end
         total++; if (rf_if.v_out !== m_vout) begin bad++; $display("FAIL rnd_v_out c=%0d got=%0b want=%0b", c, rf_if.v_out, m_vout); end
         total++; if (rf_if.r_out !== m_rout) begin bad++; $display("FAIL rnd_r_out c=%0d got=%0b want=%0b", c, rf_if.r_out, m_rout); end
         total++; if (rf_if.rs1_data !== m_rs1) begin bad++; $display("FAIL rnd_rs1 c=%0d got=%h want=%h", c, rf_if.rs1_data, m_rs1); end
         total++; if (rf_if.rs2_data !== m_rs2) begin bad++; $display("FAIL rnd_rs2 c=%0d got=%h want=%h", c, rf_if.rs2_data, m_rs2); end
      end
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      @(posedge clk);
      #1;
      test_reset();
      test_basic_read();
      test_write_read();
      test_raw();
      test_waw();
      test_stall();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
